// File: rtl/ram_pkg.sv
// Shared constants and types for the banked single-port synchronous RAM.
// The default geometry is 16K words of 16 bits, split into four equal banks.
package ram_pkg;

  localparam int ADDR_WIDTH_DEF = 14;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int NUM_BANKS      = 4;

  typedef logic [1:0] bank_idx_t;

endpackage : ram_pkg

// File: rtl/single_port_sync_ram_bank.sv
// One quarter of the RAM: a plain synchronous array with a registered read port.
// The top owns the bus, so this bank never drives anything tristate.
module single_port_sync_ram_bank #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  cs,
  input  logic                  we
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Array write port; the contents are deliberately never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && cs && we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register: loads only on a selected read, otherwise holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (cs && !we) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule : single_port_sync_ram_bank

// File: rtl/single_port_sync_ram_large.sv
// Banked single-port synchronous RAM with a shared bidirectional data bus.
// The two address MSBs pick the bank; the remainder addresses a word inside it.
module single_port_sync_ram_large
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs_input,
  input  logic                  we,
  input  logic                  oe
);

  localparam int BANK_ADDR_WIDTH = ADDR_WIDTH - 2;

  bank_idx_t                  bank_s;
  logic [BANK_ADDR_WIDTH-1:0] offset_s;
  logic [NUM_BANKS-1:0]       bank_cs_s;
  logic [DATA_WIDTH-1:0]      bank_rdata_s [NUM_BANKS];
  bank_idx_t                  bank_sel_r;
  logic [DATA_WIDTH-1:0]      rd_data_s;
  logic                       drive_en_s;

  assign bank_s   = addr[ADDR_WIDTH-1:ADDR_WIDTH-2];
  assign offset_s = addr[BANK_ADDR_WIDTH-1:0];

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    assign bank_cs_s[k] = cs_input & (bank_s == bank_idx_t'(k));

    single_port_sync_ram_bank #(
      .ADDR_WIDTH (BANK_ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .addr  (offset_s),
      .wdata (data),
      .rdata (bank_rdata_s[k]),
      .cs    (bank_cs_s[k]),
      .we    (we)
    );
  end

  // Remember which bank served the last read so the output mux stays stable until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel_r <= 2'd0;
    end else if (cs_input && !we) begin
      bank_sel_r <= bank_s;
    end else begin
      bank_sel_r <= bank_sel_r;
    end
  end

  // Read-data mux across the banks.
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    case (bank_sel_r)
      2'd0:    rd_data_s = bank_rdata_s[0];
      2'd1:    rd_data_s = bank_rdata_s[1];
      2'd2:    rd_data_s = bank_rdata_s[2];
      2'd3:    rd_data_s = bank_rdata_s[3];
      default: rd_data_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Never drive while we=1: the writer owns the bus then, even if oe is also high.
  assign drive_en_s = cs_input & oe & ~we & ~rst;
  assign data       = drive_en_s ? rd_data_s : {DATA_WIDTH{1'bz}};

endmodule : single_port_sync_ram_large

// File: tb/tb_single_port_sync_ram_large.sv
// Directed plus randomized bench for the banked RAM, checked against an address-keyed
// associative-array model of the memory.
module tb_single_port_sync_ram_large;

  logic        clk;
  logic        rst;
  logic [13:0] addr;
  wire  [15:0] data;
  logic        cs_input;
  logic        we;
  logic        oe;
  logic        tb_drive;
  logic [15:0] tb_wdata;

  int checks;
  int failures;

  logic [15:0] model [int];
  int          addrs_q [$];
  logic [15:0] zval;

  assign data = tb_drive ? tb_wdata : 16'hzzzz;

  single_port_sync_ram_large dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data     (data),
    .cs_input (cs_input),
    .we       (we),
    .oe       (oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int a, input logic [15:0] v, input logic oe_v);
    addr     = 14'(a);
    cs_input = 1'b1;
    we       = 1'b1;
    oe       = oe_v;
    tb_drive = 1'b1;
    tb_wdata = v;
    @(posedge clk);
    #1;
    if (!model.exists(a)) addrs_q.push_back(a);
    model[a] = v;
    tb_drive = 1'b0;
    we       = 1'b0;
    cs_input = 1'b0;
    oe       = 1'b0;
  endtask

  task automatic do_read(input int a, input string tag);
    addr     = 14'(a);
    cs_input = 1'b1;
    we       = 1'b0;
    oe       = 1'b1;
    tb_drive = 1'b0;
    @(posedge clk);
    #1;
    check(tag, data, model[a]);
  endtask

  initial begin
    logic [15:0] vals [4];
    int          bases [4];
    checks   = 0;
    failures = 0;
    zval     = 16'hzzzz;
    rst      = 1'b1;
    addr     = 14'h0000;
    cs_input = 1'b1;
    we       = 1'b0;
    oe       = 1'b1;
    tb_drive = 1'b0;
    tb_wdata = 16'h0000;

    // Reset: bus released even though a read is requested, read register cleared.
    repeat (2) @(posedge clk);
    #1;
    check("reset_bus_z", data, zval);
    rst = 1'b0;
    #1;
    check("reset_rdreg_zero", data, 16'h0000);
    cs_input = 1'b0;
    oe       = 1'b0;

    // Scenario 1: top of bank 0.
    vals[0] = 16'h1234; vals[1] = 16'hABCD; vals[2] = 16'h0001; vals[3] = 16'hFFFF;
    for (int i = 0; i < 4; i++) do_write(32'h0FFC + i, vals[i], 1'b0);
    for (int i = 0; i < 4; i++) do_read(32'h0FFC + i, "bank0_top_read");

    // Scenario 2: top of every other bank with random data, then no cross-bank aliasing.
    bases[0] = 32'h0FFC; bases[1] = 32'h1FFC; bases[2] = 32'h2FFC; bases[3] = 32'h3FFC;
    for (int b = 1; b < 4; b++)
      for (int i = 0; i < 4; i++) do_write(bases[b] + i, 16'($urandom), 1'b0);
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 4; i++) do_read(bases[b] + i, "bank_alias_read");

    // Scenario 3: first word of banks 0 and 1.
    do_write(32'h0000, 16'hAAAA, 1'b0);
    do_write(32'h1000, 16'h5555, 1'b0);
    do_read(32'h0000, "addr_0000");
    do_read(32'h1000, "addr_1000");

    // Scenario 4: deselected write is ignored; bus idle when deselected or oe low.
    do_write(32'h0010, 16'h1111, 1'b0);
    addr = 14'h0010; cs_input = 1'b0; we = 1'b1; oe = 1'b1;
    tb_drive = 1'b1; tb_wdata = 16'hDEAD;
    @(posedge clk);
    #1;
    tb_drive = 1'b0; we = 1'b0;
    #1;
    check("cs0_bus_z", data, zval);
    do_read(32'h0010, "cs0_write_ignored");
    oe = 1'b0;
    #1;
    check("oe0_bus_z", data, zval);

    // Scenario 5: reset during a read, then contents survive reset.
    addr = 14'h0FFF; cs_input = 1'b1; we = 1'b0; oe = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_read_bus_z", data, zval);
    rst = 1'b0;
    #1;
    check("rst_read_rdreg_zero", data, 16'h0000);
    @(posedge clk);
    #1;
    check("rst_contents_kept", data, model[32'h0FFF]);

    // A write while reset is asserted must not land.
    addr = 14'h0FFE; cs_input = 1'b1; we = 1'b1; oe = 1'b0; rst = 1'b1;
    tb_drive = 1'b1; tb_wdata = 16'hBEEF;
    @(posedge clk);
    #1;
    tb_drive = 1'b0; we = 1'b0; rst = 1'b0;
    do_read(32'h0FFE, "rst_write_suppressed");

    // Scenario 6: read-after-write, and a write with oe also high.
    do_write(32'h2000, 16'h7777, 1'b0);
    do_read(32'h2000, "raw_2000");
    do_write(32'h2001, 16'h4242, 1'b1);
    do_read(32'h2001, "we_oe_write");

    // Randomized mix of writes and reads of previously written words.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        do_write(int'($urandom_range(16383, 0)), 16'($urandom), 1'($urandom_range(1, 0)));
      end else begin
        do_read(addrs_q[$urandom_range(addrs_q.size() - 1, 0)], "random_read");
      end
    end

    // RAM must release the bus when we=1, even with oe=1 and a non-zero read register.
    do_read(32'h2000, "raw_2000_again");
    addr = 14'h3F00; cs_input = 1'b1; we = 1'b1; oe = 1'b1; tb_drive = 1'b0;
    #1;
    check("we_oe_bus_z", data, zval);
    cs_input = 1'b0; we = 1'b0; oe = 1'b0;

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_single_port_sync_ram_large
